// File: rtl/i2cm_p2s_tx_if.sv
// i2cm_p2s_tx_if: request/status and open-drain pad signals of the I2C byte transmitter
interface i2cm_p2s_tx_if;
    logic       i_tx_req;
    logic [7:0] i_tx_data;
    logic       i_gen_start;
    logic       i_gen_stop;
    logic       i_sda_in;
    logic       o_scl_oe;
    logic       o_sda_oe;
    logic       o_busy;
    logic       o_done;
    logic       o_nack;
    modport master (
        output i_tx_req, i_tx_data, i_gen_start, i_gen_stop, i_sda_in,
        input  o_scl_oe, o_sda_oe, o_busy, o_done, o_nack
    );
    modport slave (
        input  i_tx_req, i_tx_data, i_gen_start, i_gen_stop, i_sda_in,
        output o_scl_oe, o_sda_oe, o_busy, o_done, o_nack
    );
endinterface

// File: rtl/i2cm_p2s_tx.sv
// i2cm_p2s_tx: I2C master byte serialiser with optional START/RESTART/STOP framing and ACK sampling
module i2cm_p2s_tx #(
    parameter int QTR = 4
) (
    input logic          clk,
    input logic          rst,
    i2cm_p2s_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RESTART, START, DATA, ACK, STOP, DONE} state_t;
    state_t     state, n_state;
    logic [7:0] q, n_q, shift, n_shift;
    logic [1:0] phase, n_phase;
    logic [2:0] bit_cnt, n_bit;
    logic       held, n_held, stop_f, acc, last_q, n_scl, n_sda;
    always_comb begin
        n_state = state;
        n_q     = q;
        n_phase = phase;
        n_bit   = bit_cnt;
        n_shift = shift;
        n_held  = held;
        acc     = bus.i_tx_req && !bus.o_busy;
        last_q  = q == 8'(QTR - 1);
        if (state == IDLE || state == DONE) begin
            n_state = IDLE;
            n_q     = '0;
            n_phase = '0;
            n_bit   = '0;
            if (acc) begin
                n_state = !bus.i_gen_start ? DATA : held ? RESTART : START;
                n_shift = bus.i_tx_data;
            end
        end else begin
            n_q = last_q ? '0 : q + 8'd1;
            if (last_q) begin
                n_phase = phase + 2'd1;
                case (state)
                    RESTART: if (phase == 2'd1) begin
                        n_state = START;
                        n_phase = '0;
                    end
                    START: if (phase == 2'd1) begin
                        n_state = DATA;
                        n_phase = '0;
                    end
                    DATA: if (phase == 2'd3) begin
                        n_shift = {shift[6:0], 1'b0};
                        n_bit   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) n_state = ACK;
                    end
                    ACK: if (phase == 2'd3) begin
                        n_state = stop_f ? STOP : DONE;
                        n_held  = stop_f ? held : 1'b1;
                    end
                    STOP: if (phase == 2'd2) begin
                        n_state = DONE;
                        n_phase = '0;
                        n_held  = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
        // Without a STOP the bus stays owned: SCL is kept low between transfers
        n_scl = (n_state == IDLE || n_state == DONE) ? n_held :
                (n_state == DATA || n_state == ACK) ? (n_phase < 2'd2) :
                (n_state == RESTART || n_state == STOP) ? (n_phase == 2'd0) : 1'b0;
        n_sda = (n_state == START) | ((n_state == DATA) & ~n_shift[7]) |
                ((n_state == STOP) & (n_phase != 2'd2));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            q            <= '0;
            phase        <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            held         <= 1'b0;
            stop_f       <= 1'b0;
            bus.o_scl_oe <= 1'b0;
            bus.o_sda_oe <= 1'b0;
            bus.o_busy   <= 1'b0;
            bus.o_done   <= 1'b0;
            bus.o_nack   <= 1'b0;
        end else begin
            state        <= n_state;
            q            <= n_q;
            phase        <= n_phase;
            bit_cnt      <= n_bit;
            shift        <= n_shift;
            held         <= n_held;
            if (acc) stop_f <= bus.i_gen_stop;
            if (state == ACK && phase == 2'd2 && last_q) bus.o_nack <= bus.i_sda_in;
            bus.o_scl_oe <= n_scl;
            bus.o_sda_oe <= n_sda;
            bus.o_busy   <= !(n_state == IDLE || n_state == DONE);
            bus.o_done   <= n_state == DONE;
        end
    end
endmodule

// File: tb/tb_i2cm_p2s_tx.sv
// tb_i2cm_p2s_tx: vector table, corner sequences and random transfers against a bus-level model
module tb_i2cm_p2s_tx;
    localparam int QTR = 4;
    typedef struct {
        logic [7:0] d;
        bit         st;
        bit         sp;
        bit         ak;
        int         lat;
        bit         nack;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   held_m = 1'b0;
    bit   nack_m = 1'b0;
    vec_t tbl[8];
    i2cm_p2s_tx_if bus();
    i2cm_p2s_tx #(.QTR(QTR)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("gap_scl", bus.o_scl_oe, held_m);
            chk("gap_nack", bus.o_nack, nack_m);
            chk("gap_busy", bus.o_busy, 0);
        end
    endtask
    task automatic xfer(input logic [7:0] d, input bit st, input bit sp, input bit ak,
                        input int lat, input bit inj);
        logic [15:0] gb, eb;
        int nr, ne, n, starts, stops;
        logic ps, pd, cs, cd;
        eb = '0;
        ne = 0;
        if (st && held_m) begin eb = {eb[14:0], 1'b1}; ne++; end
        for (int i = 7; i >= 0; i--) begin eb = {eb[14:0], d[i]}; ne++; end
        eb = {eb[14:0], 1'b1};
        ne++;
        if (sp) begin eb = {eb[14:0], 1'b0}; ne++; end
        idle_gap(3);
        bus.i_tx_req    = 1'b1;
        bus.i_tx_data   = d;
        bus.i_gen_start = st;
        bus.i_gen_stop  = sp;
        bus.i_sda_in    = ak;
        ps = ~bus.o_scl_oe;
        pd = ~bus.o_sda_oe;
        gb = '0;
        nr = 0;
        n = 0;
        starts = 0;
        stops = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            bus.i_tx_req = inj && (n == 10 || n == 50);
            if (inj) begin
                bus.i_tx_data   = ~d;
                bus.i_gen_start = ~st;
                bus.i_gen_stop  = ~sp;
            end
            cs = ~bus.o_scl_oe;
            cd = ~bus.o_sda_oe;
            if (!ps && cs) begin gb = {gb[14:0], cd}; nr++; end
            if (ps && cs && pd && !cd) starts++;
            if (ps && cs && !pd && cd) stops++;
            ps = cs;
            pd = cd;
            if (bus.o_done) break;
        end
        chk("latency", n, lat);
        chk("bits", gb, eb);
        chk("rises", nr, ne);
        chk("start_cond", starts, st);
        chk("stop_cond", stops, sp);
        chk("nack", bus.o_nack, ak);
        chk("done_busy", bus.o_busy, 0);
        held_m = !sp;
        nack_m = ak;
        bus.i_tx_req = 1'b0;
        @(negedge clk);
        chk("post_done", bus.o_done, 0);
        chk("post_scl", bus.o_scl_oe, held_m);
        chk("post_sda", bus.o_sda_oe, 0);
    endtask
    initial begin
        int dn, lat;
        logic [7:0] d;
        bit st, sp, ak;
        tbl[0] = '{8'hA5, 1, 1, 0, 165, 0};
        tbl[1] = '{8'h3C, 1, 1, 1, 165, 1};
        tbl[2] = '{8'h80, 1, 0, 0, 153, 0};
        tbl[3] = '{8'h01, 0, 0, 0, 145, 0};
        tbl[4] = '{8'hC3, 1, 0, 1, 161, 1};
        tbl[5] = '{8'h5A, 1, 1, 0, 173, 0};
        tbl[6] = '{8'hFF, 0, 1, 1, 157, 1};
        tbl[7] = '{8'h00, 1, 1, 0, 165, 0};
        bus.i_tx_req = 1'b0;
        bus.i_tx_data = '0;
        bus.i_gen_start = 1'b0;
        bus.i_gen_stop = 1'b0;
        bus.i_sda_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {bus.o_scl_oe, bus.o_sda_oe, bus.o_busy, bus.o_done, bus.o_nack}, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xfer(tbl[i].d, tbl[i].st, tbl[i].sp, tbl[i].ak, tbl[i].lat, 1'b0);
            chk("tbl_nack", bus.o_nack, tbl[i].nack);
        end
        xfer(8'h96, 1'b1, 1'b1, 1'b1, 165, 1'b1);
        // reset while DATA bit 3 is on the wire
        idle_gap(2);
        bus.i_tx_req = 1'b1;
        bus.i_tx_data = 8'h5A;
        bus.i_gen_start = 1'b1;
        bus.i_gen_stop = 1'b1;
        bus.i_sda_in = 1'b1;
        @(negedge clk);
        bus.i_tx_req = 1'b0;
        repeat (61) @(negedge clk);
        chk("mid_busy", bus.o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outs", {bus.o_scl_oe, bus.o_sda_oe, bus.o_busy, bus.o_done, bus.o_nack}, 0);
        held_m = 1'b0;
        nack_m = 1'b0;
        dn = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.o_done) dn++;
        end
        chk("rst_no_done", dn, 0);
        xfer(8'hA5, 1'b1, 1'b1, 1'b0, 165, 1'b0);
        rst = 1'b1;
        bus.i_tx_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_tx_req = 1'b0;
        chk("rst_wins", bus.o_busy, 0);
        held_m = 1'b0;
        nack_m = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            st = 1'($urandom_range(0, 1));
            sp = 1'($urandom_range(0, 1));
            ak = 1'($urandom_range(0, 1));
            lat = 1 + 9 * 4 * QTR + (st ? (held_m ? 4 : 2) * QTR : 0) + (sp ? 3 * QTR : 0);
            xfer(d, st, sp, ak, lat, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
